cam_query_sequencer: RTL and testbench

CAM_QUERY_SEQUENCER -- requirements
Module: cam_query_sequencer

---
 rtl/cam_seq_pkg.sv | 22 ++
 rtl/cam_key_shreg.sv | 39 +++
 rtl/cam_query_sequencer.sv | 143 ++++++++++++++
 tb/tb_cam_query_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cam_seq_pkg.sv
// Shared types and default dimensions for the camouflaged-core query sequencer.
// Holds the sequencer state encoding and the saturating mismatch-counter helper.
package cam_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_HOLD  = 2'd2
    } seq_state_t;

    localparam int KEY_W_DEF  = 12;
    localparam int PI_W_DEF   = 36;
    localparam int PO_W_DEF   = 7;
    localparam int SETTLE_DEF = 2;
    localparam int SETTLE_W   = 4;
    localparam int MIS_CNT_W  = 16;

    function automatic logic [MIS_CNT_W-1:0] sat_inc(input logic [MIS_CNT_W-1:0] v);
        return (&v) ? v : v + MIS_CNT_W'(1);
    endfunction

endpackage

// File: rtl/cam_key_shreg.sv
// Serial shadow key register with a guarded commit into the active key.
// Commits requested while a query is in flight are parked until the sequencer is idle.
module cam_key_shreg
    import cam_seq_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_sin,
    input  logic             key_shift,
    input  logic             key_commit,
    input  logic             idle,
    output logic [KEY_W-1:0] key_out,
    output logic             commit_pend
);

    logic [KEY_W-1:0] shadow;

    // key_out reads the pre-shift shadow when a shift and a commit share an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow      <= '0;
            key_out     <= '0;
            commit_pend <= 1'b0;
        end else begin
            if (key_shift) begin
                shadow <= {shadow[KEY_W-2:0], key_sin};
            end
            if (idle && (key_commit || commit_pend)) begin
                key_out     <= shadow;
                commit_pend <= 1'b0;
            end else if (!idle && key_commit) begin
                commit_pend <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cam_query_sequencer.sv
// Drives one query at a time into a camouflaged core, waits SETTLE cycles, captures
// the response, compares it against the oracle value and counts mismatches.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no query in flight; accepts a query when no key commit is pending
// ST_DRIVE | core_pi held, settle counter running down to capture
// ST_HOLD  | response presented on po_*, waiting for po_ready
module cam_query_sequencer
    import cam_seq_pkg::*;
#(
    parameter int KEY_W  = KEY_W_DEF,
    parameter int PI_W   = PI_W_DEF,
    parameter int PO_W   = PO_W_DEF,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 key_sin,
    input  logic                 key_shift,
    input  logic                 key_commit,
    output logic [KEY_W-1:0]     key_out,
    input  logic                 pi_valid,
    output logic                 pi_ready,
    input  logic [PI_W-1:0]      pi_data,
    input  logic [PO_W-1:0]      pi_exp,
    output logic [PI_W-1:0]      core_pi,
    input  logic [PO_W-1:0]      core_po,
    output logic                 po_valid,
    input  logic                 po_ready,
    output logic [PO_W-1:0]      po_data,
    output logic                 po_mismatch,
    output logic [MIS_CNT_W-1:0] mis_cnt,
    input  logic                 cnt_clr
);

    seq_state_t          state;
    seq_state_t          state_nxt;
    logic [SETTLE_W-1:0] cnt;
    logic [PO_W-1:0]     exp_r;
    logic                commit_pend;
    logic                accept;
    logic                capture;
    logic                settle_dec;
    logic                resp_done;
    logic                resp_bad;

    cam_key_shreg #(
        .KEY_W (KEY_W)
    ) u_key (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_sin     (key_sin),
        .key_shift   (key_shift),
        .key_commit  (key_commit),
        .idle        (state == ST_IDLE),
        .key_out     (key_out),
        .commit_pend (commit_pend)
    );

    // a pending key commit stalls new queries so the key lands between queries
    assign pi_ready = (state == ST_IDLE) && !commit_pend;
    assign resp_bad = (core_po != exp_r);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        capture    = 1'b0;
        settle_dec = 1'b0;
        resp_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pi_valid && pi_ready) begin
                    accept    = 1'b1;
                    state_nxt = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = ST_HOLD;
                end else begin
                    settle_dec = 1'b1;
                end
            end
            ST_HOLD: begin
                if (po_valid && po_ready) begin
                    resp_done = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_pi     <= '0;
            exp_r       <= '0;
            cnt         <= '0;
            po_data     <= '0;
            po_valid    <= 1'b0;
            po_mismatch <= 1'b0;
        end else begin
            if (accept) begin
                core_pi <= pi_data;
                exp_r   <= pi_exp;
                cnt     <= SETTLE_W'(SETTLE - 1);
            end
            if (settle_dec) begin
                cnt <= cnt - SETTLE_W'(1);
            end
            if (capture) begin
                po_data     <= core_po;
                po_mismatch <= resp_bad;
                po_valid    <= 1'b1;
            end
            if (resp_done) begin
                po_valid <= 1'b0;
            end
        end
    end

    // clear takes priority over a same-edge mismatch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mis_cnt <= '0;
        end else if (cnt_clr) begin
            mis_cnt <= '0;
        end else if (capture && resp_bad) begin
            mis_cnt <= sat_inc(mis_cnt);
        end
    end

endmodule

// File: tb/tb_cam_query_sequencer.sv
// Directed bench for cam_query_sequencer with default parameters (SETTLE=2).
// The core is modelled as a constant response chosen per test.
module tb_cam_query_sequencer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_sin = 1'b0;
    logic         key_shift = 1'b0;
    logic         key_commit = 1'b0;
    logic [11:0]  key_out;
    logic         pi_valid = 1'b0;
    logic         pi_ready;
    logic [35:0]  pi_data = '0;
    logic [6:0]   pi_exp = '0;
    logic [35:0]  core_pi;
    logic [6:0]   core_val = 7'h55;
    logic         po_valid;
    logic         po_ready = 1'b0;
    logic [6:0]   po_data;
    logic         po_mismatch;
    logic [15:0]  mis_cnt;
    logic         cnt_clr = 1'b0;

    int n_checks = 0;
    int n_pass = 0;

    cam_query_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_sin     (key_sin),
        .key_shift   (key_shift),
        .key_commit  (key_commit),
        .key_out     (key_out),
        .pi_valid    (pi_valid),
        .pi_ready    (pi_ready),
        .pi_data     (pi_data),
        .pi_exp      (pi_exp),
        .core_pi     (core_pi),
        .core_po     (core_val),
        .po_valid    (po_valid),
        .po_ready    (po_ready),
        .po_data     (po_data),
        .po_mismatch (po_mismatch),
        .mis_cnt     (mis_cnt),
        .cnt_clr     (cnt_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_bits(input logic [11:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            key_sin   = bits[i];
            key_shift = 1'b1;
            tick();
        end
        key_shift = 1'b0;
        key_sin   = 1'b0;
    endtask

    // returns just after the accept edge T
    task automatic send(input logic [35:0] d, input logic [6:0] e);
        pi_data  = d;
        pi_exp   = e;
        pi_valid = 1'b1;
        tick();
        pi_valid = 1'b0;
    endtask

    task automatic ack();
        po_ready = 1'b1;
        tick();
        po_ready = 1'b0;
    endtask

    initial begin
        #12 rst_n = 1'b1;
        tick();
        chk("rst_pi_ready", 64'(pi_ready), 64'h1);
        chk("rst_key_out", 64'(key_out), 64'h0);
        chk("rst_po_valid", 64'(po_valid), 64'h0);
        chk("rst_core_pi", 64'(core_pi), 64'h0);
        chk("rst_po_data", 64'(po_data), 64'h0);
        chk("rst_mis_cnt", 64'(mis_cnt), 64'h0);

        shift_bits(12'hB29, 12);
        chk("key_before_commit", 64'(key_out), 64'h0);
        key_commit = 1'b1;
        tick();
        key_commit = 1'b0;
        chk("key_commit_b29", 64'(key_out), 64'hB29);

        key_sin = 1'b1; key_shift = 1'b1; key_commit = 1'b1;
        tick();
        key_sin = 1'b0; key_shift = 1'b0; key_commit = 1'b0;
        chk("key_shift_commit_preshift", 64'(key_out), 64'hB29);
        key_commit = 1'b1;
        tick();
        key_commit = 1'b0;
        chk("key_commit_653", 64'(key_out), 64'h653);

        core_val = 7'h55;
        send(36'h123456789, 7'h55);
        chk("q1_core_pi", 64'(core_pi), 64'h123456789);
        chk("q1_pi_ready_T", 64'(pi_ready), 64'h0);
        chk("q1_po_valid_T", 64'(po_valid), 64'h0);
        pi_data = 36'hFFFFFFFFF;
        pi_exp  = 7'h00;
        tick();
        chk("q1_po_valid_T1", 64'(po_valid), 64'h0);
        tick();
        chk("q1_po_valid_T2", 64'(po_valid), 64'h1);
        chk("q1_po_data", 64'(po_data), 64'h55);
        chk("q1_po_mismatch", 64'(po_mismatch), 64'h0);
        chk("q1_mis_cnt", 64'(mis_cnt), 64'h0);
        chk("q1_core_pi_hold", 64'(core_pi), 64'h123456789);
        ack();
        chk("q1_po_valid_ack", 64'(po_valid), 64'h0);
        chk("q1_pi_ready_idle", 64'(pi_ready), 64'h1);
        tick();
        chk("q1_core_pi_kept", 64'(core_pi), 64'h123456789);

        send(36'h0AAAAAAAA, 7'h54);
        tick();
        tick();
        core_val = 7'h11;
        for (int i = 0; i < 5; i++) begin
            chk("q2_hold_po_valid", 64'(po_valid), 64'h1);
            chk("q2_hold_po_data", 64'(po_data), 64'h55);
            chk("q2_hold_pi_ready", 64'(pi_ready), 64'h0);
            chk("q2_hold_mis_cnt", 64'(mis_cnt), 64'h1);
            tick();
        end
        core_val = 7'h55;
        chk("q2_po_mismatch", 64'(po_mismatch), 64'h1);
        ack();
        chk("q2_po_valid_ack", 64'(po_valid), 64'h0);

        shift_bits(12'h00F, 4);
        chk("q3_key_pre", 64'(key_out), 64'h653);
        send(36'h000000001, 7'h55);
        key_commit = 1'b1;
        tick();
        key_commit = 1'b0;
        chk("q3_key_drive", 64'(key_out), 64'h653);
        tick();
        chk("q3_po_valid", 64'(po_valid), 64'h1);
        chk("q3_key_hold", 64'(key_out), 64'h653);
        ack();
        chk("q3_key_idle", 64'(key_out), 64'h653);
        chk("q3_pi_ready_pend", 64'(pi_ready), 64'h0);
        tick();
        chk("q3_key_applied", 64'(key_out), 64'h53F);
        chk("q3_pi_ready_after", 64'(pi_ready), 64'h1);

        @(negedge clk);
        force dut.mis_cnt = 16'hFFFE;
        tick();
        release dut.mis_cnt;
        chk("sat_preload", 64'(mis_cnt), 64'hFFFE);
        send(36'h2, 7'h00);
        tick();
        tick();
        chk("sat_first", 64'(mis_cnt), 64'hFFFF);
        ack();
        tick();
        send(36'h3, 7'h00);
        tick();
        tick();
        chk("sat_second", 64'(mis_cnt), 64'hFFFF);
        ack();
        tick();
        send(36'h4, 7'h00);
        tick();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_wins", 64'(mis_cnt), 64'h0);
        chk("clr_po_mismatch", 64'(po_mismatch), 64'h1);
        ack();
        tick();
        send(36'h5, 7'h00);
        tick();
        tick();
        chk("pre_rst_mis_cnt", 64'(mis_cnt), 64'h1);
        ack();
        tick();

        send(36'hABC, 7'h00);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_key_out", 64'(key_out), 64'h0);
        chk("mid_rst_core_pi", 64'(core_pi), 64'h0);
        chk("mid_rst_po_valid", 64'(po_valid), 64'h0);
        chk("mid_rst_po_data", 64'(po_data), 64'h0);
        chk("mid_rst_mis_cnt", 64'(mis_cnt), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_pi_ready", 64'(pi_ready), 64'h1);
        for (int i = 0; i < 4; i++) begin
            chk("post_rst_no_po_valid", 64'(po_valid), 64'h0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
